// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronizer plus a per-bit stability counter for slide switches.
// Emits debounced levels, one-cycle rise/fall strobes and an any-change strobe.
module sw_debounce #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);
    localparam int unsigned   CW     = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CntMax = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2) begin : g_param_check
        $error("STABLE_CYCLES must be at least 2");
    end

    logic [WIDTH-1:0]         s1;
    logic [WIDTH-1:0]         s2;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic [WIDTH-1:0]         sw_d;
    logic [WIDTH-1:0]         rise_d;
    logic [WIDTH-1:0]         fall_d;

    // Pure flop chain: metastability may only appear on s1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_i;
            s2 <= s1;
        end
    end

    // Any return to the current level before qualification discards the partial count.
    always_comb begin
        cnt_d  = cnt_q;
        sw_d   = sw_o;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == sw_o[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CntMax) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i]  = '0;
                sw_d[i]   = s2[i];
                rise_d[i] = s2[i];
                fall_d[i] = ~s2[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            sw_o    <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            sw_chg  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sw_o    <= sw_d;
            sw_rise <= rise_d;
            sw_fall <= fall_d;
            sw_chg  <= |{rise_d, fall_d};
        end
    end
endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with STABLE_CYCLES=4: expected per-cycle output
// records are queued as stimulus is driven and popped at each falling clock edge.
`timescale 1ns / 1ps
module tb_sw_debounce;
    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    typedef struct packed {
        logic [W-1:0] o;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] sw_i = '0;
    logic [W-1:0] sw_o;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_chg;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    sw_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(S)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_i   (sw_i),
        .sw_o   (sw_o),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_chg (sw_chg)
    );

    always #50 clk = ~clk;

    function automatic exp_t mk(input logic [W-1:0] o, input logic [W-1:0] r,
                                input logic [W-1:0] f, input logic c);
        exp_t e;
        e.o    = o;
        e.rise = r;
        e.fall = f;
        e.chg  = c;
        return e;
    endfunction

    // Clean step old->new: unchanged through E(S), update + strobes after E(S+1), quiet after.
    function automatic void push_step(input logic [W-1:0] old_v, input logic [W-1:0] new_v);
        for (int k = 0; k <= int'(S) + 2; k++) begin
            if (k <= int'(S)) exp_q.push_back(mk(old_v, '0, '0, 1'b0));
            else if (k == int'(S) + 1)
                exp_q.push_back(mk(new_v, new_v & ~old_v, old_v & ~new_v, (new_v != old_v)));
            else exp_q.push_back(mk(new_v, '0, '0, 1'b0));
        end
    endfunction

    task automatic test_reset();
        exp_t e;
        exp_t got;
        #1 rst = 1'b1;
        sw_i = 16'h0014;
        #9;
        got = {sw_o, sw_rise, sw_fall, sw_chg};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h want 0", got);
        end
        #11 rst = 1'b0;
        push_step(16'h0000, 16'h0014);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = {sw_o, sw_rise, sw_fall, sw_chg};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_step E%0d: got o=%h r=%h f=%h c=%b want o=%h r=%h f=%h c=%b",
                         k, got.o, got.rise, got.fall, got.chg, e.o, e.rise, e.fall, e.chg);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        exp_t got;
        for (int j = 0; j < 12; j++) begin
            sw_i = (j < 3) ? 16'h0015 : 16'h0014;
            exp_q.push_back(mk(16'h0014, '0, '0, 1'b0));
            @(negedge clk);
            e   = exp_q.pop_front();
            got = {sw_o, sw_rise, sw_fall, sw_chg};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL glitch cyc%0d: got o=%h r=%h f=%h c=%b want o=%h r=%h f=%h c=%b",
                         j, got.o, got.rise, got.fall, got.chg, e.o, e.rise, e.fall, e.chg);
            end
        end
    endtask

    task automatic test_step(input string name, input logic [W-1:0] old_v,
                             input logic [W-1:0] new_v);
        exp_t e;
        exp_t got;
        sw_i = new_v;
        push_step(old_v, new_v);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = {sw_o, sw_rise, sw_fall, sw_chg};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s E%0d: got o=%h r=%h f=%h c=%b want o=%h r=%h f=%h c=%b",
                         name, k, got.o, got.rise, got.fall, got.chg, e.o, e.rise, e.fall, e.chg);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        exp_t got;
        sw_i = 16'h00FF;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(16'h8000, '0, '0, 1'b0));
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = {sw_o, sw_rise, sw_fall, sw_chg};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL midrst_pre E%0d: got o=%h want o=%h", k, got.o, e.o);
            end
        end
        #10 rst = 1'b1;
        #10;
        got = {sw_o, sw_rise, sw_fall, sw_chg};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL midrst_async: got %h want 0", got);
        end
        #20 rst = 1'b0;
        push_step(16'h0000, 16'h00FF);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = {sw_o, sw_rise, sw_fall, sw_chg};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL midrst_requal E%0d: got o=%h r=%h f=%h c=%b want o=%h r=%h f=%h c=%b",
                         k, got.o, got.rise, got.fall, got.chg, e.o, e.rise, e.fall, e.chg);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        exp_t got;
        for (int j = 0; j < 10; j++) begin
            sw_i = (j % 2 == 0) ? 16'h00FF : 16'h007F;
            exp_q.push_back(mk(16'h007F, '0, '0, 1'b0));
            @(negedge clk);
            e   = exp_q.pop_front();
            got = {sw_o, sw_rise, sw_fall, sw_chg};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL bounce cyc%0d: got o=%h r=%h f=%h c=%b want o=%h r=%h f=%h c=%b",
                         j, got.o, got.rise, got.fall, got.chg, e.o, e.rise, e.fall, e.chg);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_step("release", 16'h0014, 16'h0010);
        test_step("simultaneous", 16'h0010, 16'h8000);
        test_mid_reset();
        test_step("bounce_prep", 16'h00FF, 16'h007F);
        test_bounce();
        test_step("bounce_settle", 16'h007F, 16'h00FF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
